// File: rtl/cellrv32_bus_switch_pkg.sv
// rtl/cellrv32_bus_switch_pkg.sv - shared types and constants for the two-host bus switch
package cellrv32_bus_switch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } bus_switch_state_t;

    localparam logic bus_src_a_c = 1'b0;
    localparam logic bus_src_b_c = 1'b1;

endpackage

// File: rtl/cellrv32_bus_switch_req_buf.sv
// rtl/cellrv32_bus_switch_req_buf.sv - per-host strobe buffer holding a request until it is issued
module cellrv32_bus_switch_req_buf (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic re,
    input  logic we,
    input  logic busy_own,
    input  logic issue,
    output logic req,
    output logic req_we
);

    logic pend_re_q, pend_re_d;
    logic pend_we_q, pend_we_d;

    // A strobe from the current owner is a protocol violation and is not remembered.
    always_comb begin
        pend_re_d = pend_re_q;
        pend_we_d = pend_we_q;
        if (issue) begin
            pend_re_d = 1'b0;
            pend_we_d = 1'b0;
        end else if ((re | we) && !busy_own) begin
            pend_we_d = we;
            pend_re_d = ~we;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_re_q <= 1'b0;
            pend_we_q <= 1'b0;
        end else begin
            pend_re_q <= pend_re_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign req    = re | we | pend_re_q | pend_we_q;
    assign req_we = we | pend_we_q;

endmodule

// File: rtl/cellrv32_bus_switch.sv
// rtl/cellrv32_bus_switch.sv - two-host to one-device bus switch with strobe buffering
// Optional round-robin tie breaking: CELLRV32_BUS_SWITCH_ROUND_ROBIN_EN
module cellrv32_bus_switch
    import cellrv32_bus_switch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] ca_bus_addr_i,
    input  logic [31:0] ca_bus_wdata_i,
    input  logic [3:0]  ca_bus_ben_i,
    input  logic        ca_bus_re_i,
    input  logic        ca_bus_we_i,
    output logic [31:0] ca_bus_rdata_o,
    output logic        ca_bus_ack_o,
    output logic        ca_bus_err_o,
    input  logic [31:0] cb_bus_addr_i,
    input  logic [31:0] cb_bus_wdata_i,
    input  logic [3:0]  cb_bus_ben_i,
    input  logic        cb_bus_re_i,
    input  logic        cb_bus_we_i,
    output logic [31:0] cb_bus_rdata_o,
    output logic        cb_bus_ack_o,
    output logic        cb_bus_err_o,
    output logic [31:0] p_bus_addr_o,
    output logic [31:0] p_bus_wdata_o,
    output logic [3:0]  p_bus_ben_o,
    output logic        p_bus_re_o,
    output logic        p_bus_we_o,
    output logic        p_bus_src_o,
    input  logic [31:0] p_bus_rdata_i,
    input  logic        p_bus_ack_i,
    input  logic        p_bus_err_i
);

    bus_switch_state_t state_q, state_d;
    logic req_a, req_b, we_a, we_b;
    logic issue_a, issue_b, sel, prefer_b;
    logic owner_a, owner_b, resp;

    assign owner_a = (state_q == BUSY_A);
    assign owner_b = (state_q == BUSY_B);
    assign resp    = p_bus_ack_i | p_bus_err_i;

    cellrv32_bus_switch_req_buf u_buf_a (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .re       (ca_bus_re_i),
        .we       (ca_bus_we_i),
        .busy_own (owner_a),
        .issue    (issue_a),
        .req      (req_a),
        .req_we   (we_a)
    );

    cellrv32_bus_switch_req_buf u_buf_b (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .re       (cb_bus_re_i),
        .we       (cb_bus_we_i),
        .busy_own (owner_b),
        .issue    (issue_b),
        .req      (req_b),
        .req_we   (we_b)
    );

`ifdef CELLRV32_BUS_SWITCH_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (issue_a) begin
            last_d = bus_src_a_c;
        end else if (issue_b) begin
            last_d = bus_src_b_c;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= bus_src_b_c;
        end else begin
            last_q <= last_d;
        end
    end

    assign prefer_b = (last_q == bus_src_a_c);
`else
    assign prefer_b = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        issue_a = 1'b0;
        issue_b = 1'b0;
        sel     = bus_src_a_c;
        case (state_q)
            IDLE: begin
                if (req_a && !(req_b && prefer_b)) begin
                    issue_a = 1'b1;
                    state_d = BUSY_A;
                end else if (req_b) begin
                    issue_b = 1'b1;
                    sel     = bus_src_b_c;
                    state_d = BUSY_B;
                end
            end
            BUSY_A: begin
                if (resp) begin
                    state_d = IDLE;
                end
            end
            BUSY_B: begin
                sel = bus_src_b_c;
                if (resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign p_bus_addr_o  = (sel == bus_src_b_c) ? cb_bus_addr_i  : ca_bus_addr_i;
    assign p_bus_wdata_o = (sel == bus_src_b_c) ? cb_bus_wdata_i : ca_bus_wdata_i;
    assign p_bus_ben_o   = (sel == bus_src_b_c) ? cb_bus_ben_i   : ca_bus_ben_i;
    assign p_bus_src_o   = sel;
    assign p_bus_we_o    = (issue_a & we_a) | (issue_b & we_b);
    assign p_bus_re_o    = (issue_a & ~we_a) | (issue_b & ~we_b);

    assign ca_bus_ack_o   = owner_a & p_bus_ack_i;
    assign ca_bus_err_o   = owner_a & p_bus_err_i;
    assign ca_bus_rdata_o = owner_a ? p_bus_rdata_i : 32'h0;
    assign cb_bus_ack_o   = owner_b & p_bus_ack_i;
    assign cb_bus_err_o   = owner_b & p_bus_err_i;
    assign cb_bus_rdata_o = owner_b ? p_bus_rdata_i : 32'h0;

endmodule

// File: tb/tb_cellrv32_bus_switch.sv
// tb/tb_cellrv32_bus_switch.sv - randomized scoreboard bench for cellrv32_bus_switch
module tb_cellrv32_bus_switch;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] h_addr [2];
    logic [31:0] h_wdata[2];
    logic [3:0]  h_ben  [2];
    logic        h_re   [2];
    logic        h_we   [2];
    logic [31:0] p_rdata;
    logic        p_ack, p_err;

    logic [31:0] ca_rdata, cb_rdata, p_addr, p_wdata;
    logic [3:0]  p_ben;
    logic        ca_ack, ca_err, cb_ack, cb_err, p_re, p_we, p_src;

    always #5 clk = ~clk;

    cellrv32_bus_switch dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .ca_bus_addr_i  (h_addr[0]),
        .ca_bus_wdata_i (h_wdata[0]),
        .ca_bus_ben_i   (h_ben[0]),
        .ca_bus_re_i    (h_re[0]),
        .ca_bus_we_i    (h_we[0]),
        .ca_bus_rdata_o (ca_rdata),
        .ca_bus_ack_o   (ca_ack),
        .ca_bus_err_o   (ca_err),
        .cb_bus_addr_i  (h_addr[1]),
        .cb_bus_wdata_i (h_wdata[1]),
        .cb_bus_ben_i   (h_ben[1]),
        .cb_bus_re_i    (h_re[1]),
        .cb_bus_we_i    (h_we[1]),
        .cb_bus_rdata_o (cb_rdata),
        .cb_bus_ack_o   (cb_ack),
        .cb_bus_err_o   (cb_err),
        .p_bus_addr_o   (p_addr),
        .p_bus_wdata_o  (p_wdata),
        .p_bus_ben_o    (p_ben),
        .p_bus_re_o     (p_re),
        .p_bus_we_o     (p_we),
        .p_bus_src_o    (p_src),
        .p_bus_rdata_i  (p_rdata),
        .p_bus_ack_i    (p_ack),
        .p_bus_err_i    (p_err)
    );

    typedef struct {
        int          cyc;
        logic        src;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic        re;
        logic        we;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        a_ack, a_err, b_ack, b_err;
        logic [31:0] a_rd, b_rd;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference: owner 0 = bus free, 1 = A, 2 = B; one pending request per host.
    int owner;
    bit pend_v[2], pend_w[2], outst[2];
    bit last_b;
    int resp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ca_ack"}, 32'(ca_ack), 0);
        check({tag, "_ca_err"}, 32'(ca_err), 0);
        check({tag, "_ca_rdata"}, ca_rdata, 0);
        check({tag, "_cb_ack"}, 32'(cb_ack), 0);
        check({tag, "_cb_err"}, 32'(cb_err), 0);
        check({tag, "_cb_rdata"}, cb_rdata, 0);
        check({tag, "_p_addr"}, p_addr, 0);
        check({tag, "_p_wdata"}, p_wdata, 0);
        check({tag, "_p_ben"}, 32'(p_ben), 0);
        check({tag, "_p_re"}, 32'(p_re), 0);
        check({tag, "_p_we"}, 32'(p_we), 0);
        check({tag, "_p_src"}, 32'(p_src), 0);
    endtask

    task automatic model_reset();
        owner = 0;
        last_b = 1'b1;
        resp_cnt = 0;
        for (int h = 0; h < 2; h++) begin
            pend_v[h] = 0;
            pend_w[h] = 0;
            outst[h]  = 0;
        end
    endtask

    task automatic model_step();
        bit   req[2], wk[2], stb[2];
        int   win;
        iss_t e;
        rsp_t r;
        for (int h = 0; h < 2; h++) begin
            stb[h] = h_re[h] | h_we[h];
            req[h] = stb[h] | pend_v[h];
            wk[h]  = stb[h] ? h_we[h] : pend_w[h];
        end
        if (owner == 0) begin
            win = -1;
            if (req[0] && req[1]) begin
`ifdef CELLRV32_BUS_SWITCH_ROUND_ROBIN_EN
                win = last_b ? 0 : 1;
`else
                win = 0;
`endif
            end else if (req[0]) win = 0;
            else if (req[1]) win = 1;
            if (win >= 0) begin
                e.cyc = cyc; e.src = (win == 1); e.addr = h_addr[win];
                e.wdata = h_wdata[win]; e.ben = h_ben[win];
                e.we = wk[win]; e.re = !wk[win];
                iss_q.push_back(e);
                owner = win + 1;
                last_b = (win == 1);
                pend_v[win] = 0;
                resp_cnt = $urandom_range(0, 6);
            end
            for (int h = 0; h < 2; h++)
                if (h != win && stb[h]) begin pend_v[h] = 1; pend_w[h] = h_we[h]; end
        end else begin
            for (int h = 0; h < 2; h++)
                if (h != owner - 1 && stb[h]) begin pend_v[h] = 1; pend_w[h] = h_we[h]; end
            if (p_ack || p_err) begin
                r.cyc = cyc;
                r.a_ack = (owner == 1) && p_ack; r.a_err = (owner == 1) && p_err;
                r.b_ack = (owner == 2) && p_ack; r.b_err = (owner == 2) && p_err;
                r.a_rd = (owner == 1) ? p_rdata : 32'h0;
                r.b_rd = (owner == 2) ? p_rdata : 32'h0;
                rsp_q.push_back(r);
                owner = 0;
            end
        end
    endtask

    task automatic clear_strobes();
        for (int h = 0; h < 2; h++) begin h_re[h] = 0; h_we[h] = 0; end
        p_ack = 0; p_err = 0; p_rdata = 0;
    endtask

    task automatic rand_cycle(input bit allow);
        int k, resp_host;
        clear_strobes();
        resp_host = -1;
        if (owner != 0) begin
            if (resp_cnt == 0) begin
                k = $urandom_range(0, 3);
                p_ack = (k != 2);
                p_err = (k >= 2);
                p_rdata = p_ack ? $urandom : 32'h0;
                resp_host = owner - 1;
            end else resp_cnt--;
        end
        for (int h = 0; h < 2; h++) begin
            if (allow && !outst[h] && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 2);
                h_re[h] = (k != 1);
                h_we[h] = (k != 0);
                h_addr[h] = $urandom; h_wdata[h] = $urandom; h_ben[h] = 4'($urandom);
                outst[h] = 1;
            end
        end
        if (resp_host >= 0) outst[resp_host] = 0;
        model_step();
    endtask

    task automatic drain();
        int n = 0;
        while ((owner != 0 || pend_v[0] || pend_v[1]) && n < 200) begin
            @(posedge clk); #1;
            rand_cycle(0);
            n++;
        end
        check("drain_owner", owner, 0);
    endtask

    always @(negedge clk) begin
        iss_t e;
        rsp_t r;
        if (p_re || p_we) begin
            if (iss_q.size() == 0) check("issue_unexpected", 32'(p_re | p_we), 0);
            else begin
                e = iss_q.pop_front();
                check("issue_cyc", cyc, e.cyc);
                check("issue_src", 32'(p_src), 32'(e.src));
                check("issue_addr", p_addr, e.addr);
                check("issue_wdata", p_wdata, e.wdata);
                check("issue_ben", 32'(p_ben), 32'(e.ben));
                check("issue_re", 32'(p_re), 32'(e.re));
                check("issue_we", 32'(p_we), 32'(e.we));
            end
        end else if (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
            check("issue_missing", 32'(p_re | p_we), 1);
            void'(iss_q.pop_front());
        end
        if (ca_ack || ca_err || cb_ack || cb_err) begin
            if (rsp_q.size() == 0)
                check("resp_unexpected", 32'({ca_ack, ca_err, cb_ack, cb_err}), 0);
            else begin
                r = rsp_q.pop_front();
                check("resp_cyc", cyc, r.cyc);
                check("resp_flags", 32'({ca_ack, ca_err, cb_ack, cb_err}),
                      32'({r.a_ack, r.a_err, r.b_ack, r.b_err}));
                check("resp_ca_rdata", ca_rdata, r.a_rd);
                check("resp_cb_rdata", cb_rdata, r.b_rd);
            end
        end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
            check("resp_missing", 32'({ca_ack, ca_err, cb_ack, cb_err}), 1);
            void'(rsp_q.pop_front());
        end
    end

    initial begin
        rstn = 1'b0;
        for (int h = 0; h < 2; h++) begin
            h_addr[h] = 0; h_wdata[h] = 0; h_ben[h] = 0;
        end
        clear_strobes();
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rstn = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rand_cycle(1);
        end
        drain();

        // Reset while B owns the bus and A sits in its buffer.
        @(posedge clk); #1;
        clear_strobes();
        h_re[1] = 1; h_addr[1] = 32'h2000_0040; h_wdata[1] = 0; h_ben[1] = 4'hf; outst[1] = 1;
        model_step();
        resp_cnt = 100;
        @(posedge clk); #1;
        clear_strobes();
        h_we[0] = 1; h_addr[0] = 32'h0000_0100; h_wdata[0] = 32'h1234_5678; h_ben[0] = 4'h3; outst[0] = 1;
        model_step();
        @(posedge clk); #1;
        clear_strobes();
        rstn = 1'b0;
        for (int h = 0; h < 2; h++) begin
            h_addr[h] = 0; h_wdata[h] = 0; h_ben[h] = 0;
        end
        model_reset();
        @(negedge clk);
        check_zero("reset_mid");
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        p_ack = 1; p_rdata = 32'hDEAD_BEEF;
        model_step();
        @(negedge clk);
        check("late_ack_a", 32'({ca_ack, ca_err}), 0);
        check("late_ack_b", 32'({cb_ack, cb_err}), 0);
        check("late_ack_rdata", cb_rdata, 0);
        @(posedge clk); #1;
        clear_strobes();
        model_step();
        @(negedge clk);
        check("buffer_cleared", 32'({p_re, p_we}), 0);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            rand_cycle(1);
        end
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("iss_q_left", iss_q.size(), 0);
        check("rsp_q_left", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
